fetch_imem_responder: RTL and testbench

Instruction-memory responder for the fetch stage: the memory-side end of the fetch request/hit interface. Accepts one word-aligned instruction read at a time from `fetch_tbp`, returns the word after a fixed, parameterised latency with a one-cycle `ihit`, and supports aborts from fetch (PC redirect/flush). Backing store is a word array loaded through a program port, used by the tensor-core datapath and its fetch testbenches.

---
 rtl/fetch_imem_responder.sv | 111 +++++++++++
 tb/tb_fetch_imem_responder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_imem_responder.sv
// Instruction-memory responder for the fetch stage: one word read in flight,
// fixed-latency single-cycle hit strobe, abortable by fetch flush/redirect.
module fetch_imem_responder #(
  parameter  int DEPTH = 256,
  parameter  int LAT   = 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          iren,
  input  logic [31:0]   iaddr,
  input  logic          flush,
  output logic          ihit,
  output logic [31:0]   iload,
  output logic          ifault,
  output logic          ibusy,
  input  logic          prog_wen,
  input  logic [AW-1:0] prog_addr,
  input  logic [31:0]   prog_data
);

  localparam int CW = $clog2(LAT + 1);
  // Wait-state count loaded on acceptance; unused when LAT is 1.
  localparam logic [CW-1:0] CNT_INIT = (LAT > 1) ? CW'(LAT - 2) : '0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [31:0]   req_addr;
  logic          accept;
  logic          resp_enter;
  logic [31:0]   rd_addr;
  logic          rd_fault;
  logic [31:0]   mem [DEPTH];

  // Next-state and latency counting; acceptance only from IDLE.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (iren && !flush) begin
          accept = 1'b1;
          if (LAT == 1) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (flush || !iren) begin
          state_nxt = IDLE;
        end else if (cnt == '0) begin
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Response source: with LAT=1 the read happens on the acceptance edge,
  // before req_addr has been captured, so the live address is used.
  always_comb begin
    resp_enter = (state_nxt == RESP) && (state != RESP);
    rd_addr    = accept ? iaddr : req_addr;
    rd_fault   = (rd_addr[1:0] != 2'b00) || (rd_addr[31:AW+2] != '0);
  end

  // State, counter and request address registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      cnt      <= '0;
      req_addr <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) req_addr <= iaddr;
    end
  end

  // Response data captured on RESP entry and held until the next entry;
  // a same-edge program write is not yet visible, so old data returns.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      iload  <= '0;
      ifault <= 1'b0;
    end else if (resp_enter) begin
      iload  <= rd_fault ? 32'h0 : mem[rd_addr[AW+1:2]];
      ifault <= rd_fault;
    end
  end

  // Program port writes the backing store in any state; contents not reset.
  always_ff @(posedge CLK) begin
    if (prog_wen) mem[prog_addr] <= prog_data;
  end

  assign ihit  = (state == RESP) && !flush;
  assign ibusy = (state != IDLE);

endmodule

// File: tb/tb_fetch_imem_responder.sv
// Directed bench for fetch_imem_responder: a LAT=2 instance for the main
// protocol and a LAT=1 instance for the write/read collision case.
module tb_fetch_imem_responder;

  logic        CLK = 1'b0;
  logic        nRST;

  logic        a_iren, a_flush, a_ihit, a_ifault, a_ibusy, a_prog_wen;
  logic [31:0] a_iaddr, a_iload, a_prog_data;
  logic [7:0]  a_prog_addr;

  logic        b_iren, b_flush, b_ihit, b_ifault, b_ibusy, b_prog_wen;
  logic [31:0] b_iaddr, b_iload, b_prog_data;
  logic [7:0]  b_prog_addr;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  fetch_imem_responder #(.DEPTH(256), .LAT(2)) dut_a (
    .CLK(CLK), .nRST(nRST), .iren(a_iren), .iaddr(a_iaddr), .flush(a_flush),
    .ihit(a_ihit), .iload(a_iload), .ifault(a_ifault), .ibusy(a_ibusy),
    .prog_wen(a_prog_wen), .prog_addr(a_prog_addr), .prog_data(a_prog_data)
  );

  fetch_imem_responder #(.DEPTH(256), .LAT(1)) dut_b (
    .CLK(CLK), .nRST(nRST), .iren(b_iren), .iaddr(b_iaddr), .flush(b_flush),
    .ihit(b_ihit), .iload(b_iload), .ifault(b_ifault), .ibusy(b_ibusy),
    .prog_wen(b_prog_wen), .prog_addr(b_prog_addr), .prog_data(b_prog_data)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic prog_a(input logic [7:0] idx, input logic [31:0] data);
    a_prog_wen = 1'b1; a_prog_addr = idx; a_prog_data = data;
    tick();
    a_prog_wen = 1'b0;
  endtask

  // Present a request on dut_a (iren left high) and count edges until ihit.
  task automatic read_a(input string tag, input logic [31:0] addr,
                        input logic [31:0] exp_data, input logic exp_fault,
                        input int exp_lat);
    int n;
    a_iren = 1'b1; a_iaddr = addr;
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (a_ihit) begin n = i; break; end
    end
    if (n == 0) n = 99;
    check({tag, "_lat"}, n, exp_lat);
    check({tag, "_data"}, a_iload, exp_data);
    check({tag, "_fault"}, {31'b0, a_ifault}, {31'b0, exp_fault});
  endtask

  task automatic idle_a();
    a_iren = 1'b0; a_flush = 1'b0;
    tick();
  endtask

  initial begin
    int lat_b;
    nRST = 1'b0;
    a_iren = 0; a_flush = 0; a_iaddr = 0; a_prog_wen = 0; a_prog_addr = 0; a_prog_data = 0;
    b_iren = 0; b_flush = 0; b_iaddr = 0; b_prog_wen = 0; b_prog_addr = 0; b_prog_data = 0;
    tick(); tick();
    check("rst_ihit",   {31'b0, a_ihit},   32'h0);
    check("rst_ibusy",  {31'b0, a_ibusy},  32'h0);
    check("rst_iload",  a_iload,           32'h0);
    check("rst_ifault", {31'b0, a_ifault}, 32'h0);
    nRST = 1'b1;
    tick();

    prog_a(8'd0, 32'h1111_0000);
    prog_a(8'd1, 32'h2222_1111);
    prog_a(8'd2, 32'h3333_2222);
    prog_a(8'd4, 32'hDEAD_BEEF);

    // Basic read with cycle-by-cycle view of the strobe
    a_iren = 1'b1; a_iaddr = 32'h10;
    tick();
    check("basic_wait_ihit",  {31'b0, a_ihit},  32'h0);
    check("basic_wait_ibusy", {31'b0, a_ibusy}, 32'h1);
    a_iaddr = 32'h0;  // ignored during WAIT
    tick();
    check("basic_ihit",  {31'b0, a_ihit},   32'h1);
    check("basic_iload", a_iload,           32'hDEAD_BEEF);
    check("basic_fault", {31'b0, a_ifault}, 32'h0);
    a_iren = 1'b0;
    tick();
    check("basic_after_ihit",  {31'b0, a_ihit},  32'h0);
    check("basic_after_ibusy", {31'b0, a_ibusy}, 32'h0);

    // Reset asserted mid-WAIT clears outputs immediately
    a_iren = 1'b1; a_iaddr = 32'h10;
    tick();
    check("mrst_pre_ibusy", {31'b0, a_ibusy}, 32'h1);
    nRST = 1'b0;
    #1;
    check("mrst_ibusy", {31'b0, a_ibusy}, 32'h0);
    check("mrst_ihit",  {31'b0, a_ihit},  32'h0);
    check("mrst_iload", a_iload,          32'h0);
    a_iren = 1'b0;
    tick();
    nRST = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("postrst_ihit",  {31'b0, a_ihit},  32'h0);
      check("postrst_ibusy", {31'b0, a_ibusy}, 32'h0);
    end

    // Back-to-back with fetch advancing on each hit
    read_a("b2b0", 32'h0, 32'h1111_0000, 1'b0, 2);
    read_a("b2b1", 32'h4, 32'h2222_1111, 1'b0, 3);
    read_a("b2b2", 32'h8, 32'h3333_2222, 1'b0, 3);
    a_iren = 1'b0;
    tick();
    check("b2b_nodup0", {31'b0, a_ihit}, 32'h0);
    tick();
    check("b2b_nodup1", {31'b0, a_ihit}, 32'h0);

    // Abort in WAIT
    a_iren = 1'b1; a_iaddr = 32'h0;
    tick();
    check("abw_ibusy", {31'b0, a_ibusy}, 32'h1);
    a_flush = 1'b1;
    #1;
    check("abw_ihit", {31'b0, a_ihit}, 32'h0);
    tick();
    a_flush = 1'b0; a_iren = 1'b0;
    #1;
    check("abw_after_ibusy", {31'b0, a_ibusy}, 32'h0);
    tick();
    check("abw_after_ihit", {31'b0, a_ihit}, 32'h0);

    // Abort in RESP: the strobe is suppressed in that very cycle
    a_iren = 1'b1; a_iaddr = 32'h4;
    tick();
    tick();
    a_flush = 1'b1;
    #1;
    check("abr_ihit",  {31'b0, a_ihit},  32'h0);
    check("abr_ibusy", {31'b0, a_ibusy}, 32'h1);
    tick();
    a_flush = 1'b0; a_iren = 1'b0;
    #1;
    check("abr_after_ibusy", {31'b0, a_ibusy}, 32'h0);
    check("abr_after_ihit",  {31'b0, a_ihit},  32'h0);
    tick();

    read_a("post_abort", 32'h8, 32'h3333_2222, 1'b0, 2);
    idle_a();

    // flush together with iren in IDLE: no accept
    a_iren = 1'b1; a_flush = 1'b1; a_iaddr = 32'h0;
    tick();
    check("flush_idle_ibusy", {31'b0, a_ibusy}, 32'h0);
    idle_a();

    // iren drop in the RESP cycle still yields the hit
    a_iren = 1'b1; a_iaddr = 32'h10;
    tick();
    tick();
    a_iren = 1'b0;
    #1;
    check("drop_resp_ihit", {31'b0, a_ihit}, 32'h1);
    tick();

    // Faults
    read_a("misalign", 32'h6,   32'h0, 1'b1, 2);
    idle_a();
    read_a("range",    32'h400, 32'h0, 1'b1, 2);
    idle_a();

    // LAT=1: collision returns old data, later read sees new data
    b_prog_wen = 1'b1; b_prog_addr = 8'd1; b_prog_data = 32'h55;
    tick();
    b_prog_data = 32'hAA; b_iren = 1'b1; b_iaddr = 32'h4;
    tick();
    b_prog_wen = 1'b0;
    check("coll_ihit",  {31'b0, b_ihit}, 32'h1);
    check("coll_iload", b_iload,         32'h55);
    b_iren = 1'b0;
    tick();
    check("coll_after_ihit", {31'b0, b_ihit}, 32'h0);
    b_iren = 1'b1; b_iaddr = 32'h4;
    lat_b = 99;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (b_ihit) begin lat_b = i; break; end
    end
    check("lat1_lat",   lat_b,   1);
    check("lat1_iload", b_iload, 32'hAA);
    b_iren = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
